// File: rtl/ad_capture_pkg.sv
// Shared definitions for the A/D capture buffer.
//   capture_state_e : capture state machine encoding, also reported in STATUS[1:0]
//   REG_*           : register offsets within the register window (address MSB = 1)
//   CTRL_*_BIT      : bit positions within the CONTROL register
package ad_capture_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StPost  = 2'd2,
      StDone  = 2'd3
   } capture_state_e;

   localparam logic [1:0] REG_CONTROL    = 2'd0;
   localparam logic [1:0] REG_STATUS     = 2'd1;
   localparam logic [1:0] REG_POST_COUNT = 2'd2;
   localparam logic [1:0] REG_TRIG_INDEX = 2'd3;

   localparam int unsigned CTRL_ARM_BIT   = 0;
   localparam int unsigned CTRL_CLEAR_BIT = 1;

endpackage

// File: rtl/ad_capture_ram_core.sv
// Simple dual-port sample RAM, WORDS x DATA_WIDTH.
//   clk   : clock
//   we    : write enable; be selects the byte lanes of wdata written at waddr
//   re    : read enable; rdata is loaded from raddr on the clock edge and held otherwise
//   rdata : read data, valid the cycle after re
// The read is read-first: a read and write of the same word in one cycle returns the old word.
module ad_capture_ram_core #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned WORDS      = 4096,
   localparam int unsigned ADDR_W    = $clog2(WORDS),
   localparam int unsigned BE_W      = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [BE_W-1:0]       be,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [WORDS];
   logic [DATA_WIDTH-1:0] rdata_q;

   // No reset so the array and its output register map onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (be[b]) begin
               mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
      if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ad_capture_ram.sv
// Multi-channel A/D capture buffer with pre/post-trigger freeze and Avalon-MM slave.
//   clk, reset_n             : clock, asynchronous active-low reset
//   sample_valid/channel/data: sequencer sample strobe, stored at {channel, wr_ptr}
//   trigger                  : capture trigger, level-sampled while armed
//   avs_*                    : Avalon-MM slave, read latency 1, no waitrequest;
//                              address MSB=1 selects registers, MSB=0 selects {channel, index}
//   irq                      : level interrupt, high while the capture is done
module ad_capture_ram
   import ad_capture_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned CHANNELS   = 4,
   localparam int unsigned PTR_W     = $clog2(DEPTH),
   localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned AW        = CH_W + PTR_W + 1,
   localparam int unsigned BE_W      = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sample_valid,
   input  logic [CH_W-1:0]       sample_channel,
   input  logic [DATA_WIDTH-1:0] sample_data,
   input  logic                  trigger,
   input  logic [AW-1:0]         avs_address,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [DATA_WIDTH-1:0] avs_writedata,
   input  logic [BE_W-1:0]       avs_byteenable,
   output logic [DATA_WIDTH-1:0] avs_readdata,
   output logic                  irq
);

   localparam int unsigned RAM_WORDS = CHANNELS * DEPTH;
   localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);

   capture_state_e   state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] trig_index_q, trig_index_d;
   logic [PTR_W-1:0] post_lat_q, post_lat_d;
   logic [PTR_W-1:0] post_cnt_q, post_cnt_d;
   logic [PTR_W-1:0] post_count_q;
   logic             wrapped_q, wrapped_d;
   logic             irq_q;

   logic                  reg_sel;
   logic [1:0]            reg_off;
   logic                  reg_wr;
   logic                  arm_req, clear_req;
   logic                  store, frame_done;
   logic                  host_mem_we;
   logic [AW-2:0]         host_addr;
   logic [AW-2:0]         wr_full;
   logic                  ram_we, ram_re;
   logic [RAM_AW-1:0]     ram_waddr, ram_raddr;
   logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;
   logic [BE_W-1:0]       ram_be;
   logic [DATA_WIDTH-1:0] reg_rdata, reg_rdata_q;
   logic                  rd_sel_mem_q;

   // Host access decode
   assign reg_sel   = avs_address[AW-1];
   assign reg_off   = avs_address[1:0];
   assign host_addr = avs_address[AW-2:0];
   assign reg_wr    = avs_write & reg_sel;
   assign arm_req   = reg_wr & (reg_off == REG_CONTROL) & avs_writedata[CTRL_ARM_BIT];
   assign clear_req = reg_wr & (reg_off == REG_CONTROL) & avs_writedata[CTRL_CLEAR_BIT];

   // Sample capture
   assign store      = sample_valid & ((state_q == StArmed) | (state_q == StPost));
   assign frame_done = store & (sample_channel == CH_W'(CHANNELS - 1));

   // Host memory writes only while the sequencer cannot write, so one write port suffices.
   assign host_mem_we = avs_write & ~reg_sel & ((state_q == StIdle) | (state_q == StDone));

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      wrapped_d    = wrapped_q;
      trig_index_d = trig_index_q;
      post_lat_d   = post_lat_q;
      post_cnt_d   = post_cnt_q;

      if (clear_req) begin
         state_d   = StIdle;
         wr_ptr_d  = '0;
         wrapped_d = 1'b0;
      end else begin
         if (frame_done) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
               wrapped_d = 1'b1;
            end
         end

         case (state_q)
            StIdle: begin
               if (arm_req) begin
                  state_d    = StArmed;
                  post_lat_d = post_count_q;
               end
            end
            StArmed: begin
               if (trigger) begin
                  // A frame completing with the trigger counts as pre-trigger.
                  trig_index_d = wr_ptr_q;
                  post_cnt_d   = '0;
                  state_d      = (post_lat_q == '0) ? StDone : StPost;
               end
            end
            StPost: begin
               if (frame_done) begin
                  post_cnt_d = post_cnt_q + PTR_W'(1);
                  if (post_cnt_d == post_lat_q) begin
                     state_d = StDone;
                  end
               end
            end
            StDone: begin
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         wrapped_q    <= 1'b0;
         trig_index_q <= '0;
         post_lat_q   <= PTR_W'(DEPTH / 2);
         post_cnt_q   <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         wrapped_q    <= wrapped_d;
         trig_index_q <= trig_index_d;
         post_lat_q   <= post_lat_d;
         post_cnt_q   <= post_cnt_d;
         irq_q        <= (state_d == StDone);
      end
   end

   assign irq = irq_q;

   // Host-visible POST_COUNT; the FSM only uses the copy latched at arm.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         post_count_q <= PTR_W'(DEPTH / 2);
      end else if (reg_wr && (reg_off == REG_POST_COUNT)) begin
         post_count_q <= avs_writedata[PTR_W-1:0];
      end
   end

   // RAM write mux: sequencer samples in ARMED/POST, host writes in IDLE/DONE.
   assign wr_full   = store ? {sample_channel, wr_ptr_q} : host_addr;
   assign ram_we    = store | host_mem_we;
   assign ram_waddr = wr_full[RAM_AW-1:0];
   assign ram_wdata = store ? sample_data : avs_writedata;
   assign ram_be    = store ? {BE_W{1'b1}} : avs_byteenable;
   assign ram_re    = avs_read & ~reg_sel;
   assign ram_raddr = host_addr[RAM_AW-1:0];

   ad_capture_ram_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORDS      (RAM_WORDS)
   ) u_core (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .be    (ram_be),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   always_comb begin
      reg_rdata = '0;
      case (reg_off)
         REG_STATUS: begin
            reg_rdata[1:0] = state_q;
            reg_rdata[2]   = wrapped_q;
         end
         REG_POST_COUNT: reg_rdata[PTR_W-1:0] = post_count_q;
         REG_TRIG_INDEX: reg_rdata[PTR_W-1:0] = trig_index_q;
         default:        reg_rdata = '0;
      endcase
   end

   // Readdata is the RAM output register or the register-read register, selected by the
   // source of the last read; both hold between reads, so avs_readdata holds too.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_rdata_q  <= '0;
         rd_sel_mem_q <= 1'b0;
      end else if (avs_read) begin
         rd_sel_mem_q <= ~reg_sel;
         if (reg_sel) begin
            reg_rdata_q <= reg_rdata;
         end
      end
   end

   assign avs_readdata = rd_sel_mem_q ? ram_rdata : reg_rdata_q;

endmodule

// File: tb/tb_ad_capture_ram.sv
// Directed self-checking bench for ad_capture_ram with CHANNELS=4, DEPTH=8, DATA_WIDTH=16.
module tb_ad_capture_ram;

   logic        clk;
   logic        reset_n;
   logic        sample_valid;
   logic [1:0]  sample_channel;
   logic [15:0] sample_data;
   logic        trigger;
   logic [5:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [15:0] avs_writedata;
   logic [1:0]  avs_byteenable;
   logic [15:0] avs_readdata;
   logic        irq;

   int check_cnt;
   int error_cnt;

   ad_capture_ram #(
      .DATA_WIDTH (16),
      .DEPTH      (8),
      .CHANNELS   (4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample_valid   (sample_valid),
      .sample_channel (sample_channel),
      .sample_data    (sample_data),
      .trigger        (trigger),
      .avs_address    (avs_address),
      .avs_read       (avs_read),
      .avs_write      (avs_write),
      .avs_writedata  (avs_writedata),
      .avs_byteenable (avs_byteenable),
      .avs_readdata   (avs_readdata),
      .irq            (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got !== exp) begin
         error_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] reg_addr(input logic [1:0] off);
      return {1'b1, 3'b000, off};
   endfunction

   function automatic logic [5:0] mem_addr(input logic [1:0] ch, input logic [2:0] idx);
      return {1'b0, ch, idx};
   endfunction

   task automatic bus_write(input logic [5:0] addr, input logic [15:0] data,
                            input logic [1:0] be);
      avs_address    = addr;
      avs_writedata  = data;
      avs_byteenable = be;
      avs_write      = 1'b1;
      tick();
      avs_write      = 1'b0;
   endtask

   // Issue at cycle N, sample the result one edge later.
   task automatic bus_read(input logic [5:0] addr, output logic [15:0] data);
      avs_address = addr;
      avs_read    = 1'b1;
      tick();
      avs_read    = 1'b0;
      data        = avs_readdata;
   endtask

   task automatic send_sample(input logic [1:0] ch, input logic [15:0] data, input logic trig);
      sample_valid   = 1'b1;
      sample_channel = ch;
      sample_data    = data;
      trigger        = trig;
      tick();
      sample_valid   = 1'b0;
      trigger        = 1'b0;
   endtask

   initial begin
      logic [15:0] d;
      check_cnt      = 0;
      error_cnt      = 0;
      reset_n        = 1'b0;
      sample_valid   = 1'b0;
      sample_channel = '0;
      sample_data    = '0;
      trigger        = 1'b0;
      avs_address    = '0;
      avs_read       = 1'b0;
      avs_write      = 1'b0;
      avs_writedata  = '0;
      avs_byteenable = '0;

      // Reset values
      repeat (3) tick();
      check("rst_irq", irq, 0);
      check("rst_readdata", avs_readdata, 0);
      reset_n = 1'b1;
      tick();
      bus_read(reg_addr(2'd1), d);
      check("rst_status", d, 0);
      bus_read(reg_addr(2'd2), d);
      check("rst_post_count", d, 4);
      bus_read(reg_addr(2'd3), d);
      check("rst_trig_index", d, 0);

      // Byte-lane writes in IDLE, dropped write in ARMED
      bus_write(mem_addr(2'd1, 3'd5), 16'h3C00, 2'b11);
      bus_write(mem_addr(2'd1, 3'd5), 16'h00A5, 2'b01);
      bus_read(mem_addr(2'd1, 3'd5), d);
      check("be_low_lane", d, 16'h3CA5);
      bus_write(mem_addr(2'd1, 3'd5), 16'h7700, 2'b10);
      bus_read(mem_addr(2'd1, 3'd5), d);
      check("be_high_lane", d, 16'h77A5);
      repeat (3) tick();
      check("readdata_hold", avs_readdata, 16'h77A5);
      bus_write(reg_addr(2'd0), 16'h0001, 2'b11);
      bus_read(reg_addr(2'd1), d);
      check("armed_status", d, 1);
      bus_write(mem_addr(2'd1, 3'd5), 16'hFFFF, 2'b11);
      bus_read(mem_addr(2'd1, 3'd5), d);
      check("armed_write_dropped", d, 16'h77A5);

      // Arm and clear together: clear wins
      bus_write(reg_addr(2'd0), 16'h0003, 2'b11);
      bus_read(reg_addr(2'd1), d);
      check("arm_clear_status", d, 0);

      // Capture: POST_COUNT=3, 10 frames, trigger on the last sample of frame 6
      bus_write(reg_addr(2'd2), 16'h0003, 2'b00);
      bus_read(reg_addr(2'd2), d);
      check("post_count_wr", d, 3);
      bus_write(reg_addr(2'd0), 16'h0001, 2'b11);
      for (int f = 0; f < 10; f++) begin
         for (int c = 0; c < 4; c++) begin
            send_sample(2'(c), 16'(f * 16 + c), (f == 6) && (c == 3));
         end
         if (f == 8) check("irq_before_last", irq, 0);
      end
      check("irq_done", irq, 1);
      bus_read(reg_addr(2'd1), d);
      check("done_status", d, 3'b111);
      bus_read(reg_addr(2'd3), d);
      check("trig_index", d, 6);
      bus_read(mem_addr(2'd2, 3'd1), d);
      check("mem_f9_c2", d, 16'h0092);
      bus_read(mem_addr(2'd0, 3'd0), d);
      check("mem_f8_c0", d, 16'h0080);
      bus_read(mem_addr(2'd3, 3'd7), d);
      check("mem_f7_c3", d, 16'h0073);
      bus_read(mem_addr(2'd1, 3'd2), d);
      check("mem_f2_c1", d, 16'h0021);
      for (int c = 0; c < 4; c++) send_sample(2'(c), 16'hA0 + 16'(c), 1'b1);
      bus_read(mem_addr(2'd0, 3'd2), d);
      check("done_frozen", d, 16'h0020);
      check("irq_held", irq, 1);

      // Clear in DONE
      bus_write(reg_addr(2'd0), 16'h0002, 2'b11);
      check("irq_clear", irq, 0);
      bus_read(reg_addr(2'd1), d);
      check("clear_status", d, 0);

      // POST_COUNT=0: DONE the cycle after the trigger; TRIG_INDEX shows wr_ptr reset to 0
      bus_write(reg_addr(2'd2), 16'h0000, 2'b11);
      bus_write(reg_addr(2'd0), 16'h0001, 2'b11);
      send_sample(2'd0, 16'h5555, 1'b1);
      check("pc0_irq", irq, 1);
      bus_read(reg_addr(2'd1), d);
      check("pc0_status", d, 3);
      bus_read(reg_addr(2'd3), d);
      check("pc0_trig_index", d, 0);
      send_sample(2'd0, 16'h6666, 1'b0);
      bus_read(mem_addr(2'd0, 3'd0), d);
      check("pc0_not_stored", d, 16'h5555);

      // Reset during POST
      bus_write(reg_addr(2'd0), 16'h0002, 2'b11);
      bus_write(reg_addr(2'd2), 16'h0003, 2'b11);
      bus_write(reg_addr(2'd0), 16'h0001, 2'b11);
      send_sample(2'd0, 16'h1234, 1'b1);
      bus_read(reg_addr(2'd1), d);
      check("post_status", d, 2);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_readdata", avs_readdata, 0);
      check("async_rst_irq", irq, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 4; c++) send_sample(2'(c), 16'h0BAD, 1'b1);
      end
      check("post_rst_irq", irq, 0);
      bus_read(reg_addr(2'd1), d);
      check("post_rst_status", d, 0);
      bus_read(reg_addr(2'd2), d);
      check("post_rst_post_count", d, 4);

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
      $finish;
   end

endmodule
